// File: rtl/fib_arb_ctrl_if.sv
// Requester/response bus for the two-port term generator controller.
// master = requesters plus result consumer; slave = the controller.
interface fib_arb_ctrl_if;
  logic       req0_valid;
  logic       req1_valid;
  logic [3:0] req0_n;
  logic [3:0] req1_n;
  logic       req0_ready;
  logic       req1_ready;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [8:0] rsp_data;
  logic       rsp_id;
  logic       rsp_ovf;

  modport master (
    output req0_valid, req1_valid, req0_n, req1_n, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, rsp_ovf
  );

  modport slave (
    input  req0_valid, req1_valid, req0_n, req1_n, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, rsp_ovf
  );
endinterface

// File: rtl/fib_arb_ctrl.sv
// Round-robin arbiter for two requesters sharing one external term generator:
// clears the generator, steps it n times, then presents its value as the result.
//
// state | meaning
// IDLE  | waiting for a request; grant and latch job on the same cycle
// CLEAR | one-cycle generator clear
// RUN   | step generator while the job counter is non-zero
// DONE  | result presented, held until the consumer takes it
module fib_arb_ctrl (
  input  logic               clk,
  input  logic               rst,
  fib_arb_ctrl_if.slave      bus,
  input  logic [8:0]         i_gen_val,
  output logic               o_busy,
  output logic               o_gen_clr,
  output logic               o_gen_en
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic [3:0] r_n_q;
  logic       r_id;
  logic       r_prio;

  logic       w_any;
  logic       w_gnt_id;
  logic       w_accept;
  logic       w_rdy0;
  logic       w_rdy1;
  logic       w_gen_clr;
  logic       w_gen_en;
  logic       w_rsp_valid;
  logic [8:0] w_rsp_data;
  logic       w_rsp_id;
  logic       w_rsp_ovf;

  assign w_any    = bus.req0_valid | bus.req1_valid;
  // r_prio names the requester that wins a tie; a lone requester always wins
  assign w_gnt_id = (bus.req0_valid & bus.req1_valid) ? r_prio : bus.req1_valid;

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_rdy0      = 1'b0;
    w_rdy1      = 1'b0;
    w_gen_clr   = 1'b0;
    w_gen_en    = 1'b0;
    w_rsp_valid = 1'b0;
    w_rsp_data  = 9'd0;
    w_rsp_id    = 1'b0;
    w_rsp_ovf   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any && !rst) begin
          w_accept = 1'b1;
          w_rdy0   = ~w_gnt_id;
          w_rdy1   = w_gnt_id;
          w_next   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_gen_clr = 1'b1;
        w_next    = S_RUN;
      end
      S_RUN: begin
        if (r_cnt != 4'd0) begin
          w_gen_en = 1'b1;
        end else begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_rsp_valid = 1'b1;
        w_rsp_data  = i_gen_val;
        w_rsp_id    = r_id;
        w_rsp_ovf   = (r_n_q >= 4'd14);
        if (bus.rsp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_n_q   <= 4'd0;
      r_id    <= 1'b0;
      r_prio  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt  <= w_gnt_id ? bus.req1_n : bus.req0_n;
        r_n_q  <= w_gnt_id ? bus.req1_n : bus.req0_n;
        r_id   <= w_gnt_id;
        r_prio <= ~w_gnt_id;
      end else if (w_gen_en) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  assign bus.req0_ready = w_rdy0;
  assign bus.req1_ready = w_rdy1;
  assign bus.rsp_valid  = w_rsp_valid;
  assign bus.rsp_data   = w_rsp_data;
  assign bus.rsp_id     = w_rsp_id;
  assign bus.rsp_ovf    = w_rsp_ovf;
  assign o_busy         = (r_state != S_IDLE);
  assign o_gen_clr      = w_gen_clr;
  assign o_gen_en       = w_gen_en;

endmodule

// File: doc/fib_arb_ctrl.md
FIB_ARB_CTRL -- requirements
Module: fib_arb_ctrl

Interface
REQ-001 Parameters SHALL be none; all widths are fixed as listed below.
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 req0_valid, req1_valid  input  1 each  requester 0/1 has a job pending.
REQ-005 req0_n, req1_n  input  4 each  requested term index n (0..15).
REQ-006 req0_ready, req1_ready  output  1 each  job accepted this cycle.
REQ-007 rsp_valid  output  1  result available.
REQ-008 rsp_ready  input  1  consumer takes result.
REQ-009 rsp_data  output  9  generator value after n advances.
REQ-010 rsp_id  output  1  index of the requester that owns the result.
REQ-011 rsp_ovf  output  1  result exceeded 9 bits (value wrapped).
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 gen_clr  output  1  one-cycle synchronous clear to the generator (value 0, seed 0/1).
REQ-014 gen_en  output  1  advance the generator one step.
REQ-015 gen_val  input  9  generator output, registered, updated the edge after gen_en.

Function
REQ-016 FSM states SHALL be IDLE, CLEAR, RUN, DONE.
REQ-017 IDLE: if any req_valid, grant one; matching reqX_ready=1 combinationally that cycle; latch n into cnt and into n_q, latch id; go to CLEAR.
REQ-018 reqX_ready SHALL be 0 outside IDLE and for the non-granted requester; requesters hold valid/n stable until ready.
REQ-019 Arbitration SHALL be round-robin: on simultaneous requests, grant the requester not granted last; after reset requester 0 wins the first tie.
REQ-020 A single requester SHALL be granted regardless of the round-robin pointer; the pointer updates only on a grant.
REQ-021 CLEAR: gen_clr=1 for exactly one cycle, gen_en=0; go to RUN.
REQ-022 RUN: if cnt!=0 then gen_en=1 and cnt decrements; if cnt==0 then gen_en=0 and go to DONE.
REQ-023 gen_en SHALL be asserted exactly n cycles per job, all consecutive.
REQ-024 DONE: rsp_valid=1, rsp_data=gen_val, rsp_id=latched id, rsp_ovf=(n_q>=14); on rsp_ready go to IDLE.
REQ-025 rsp_valid first rises n+3 cycles after the accept edge; n=0 gives latency 3 with rsp_data=0.
REQ-026 rsp_data/rsp_id/rsp_ovf SHALL remain stable while rsp_valid=1 and rsp_ready=0.
REQ-027 Expected rsp_data for n=0..15: 0,1,2,3,5,8,13,21,34,55,89,144,233,377,98,475 (mod 512 for n>=14).
REQ-028 A new request SHALL NOT be accepted in the DONE cycle that completes the response handshake; the earliest accept is the following IDLE cycle.
REQ-029 gen_clr and gen_en SHALL never be high in the same cycle.

Reset
REQ-030 On rst: state=IDLE, cnt=0, n_q=0, rr pointer selects requester 0 first, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_ovf=0, busy=0, gen_clr=0, gen_en=0, req_ready=0.
REQ-031 rst asserted mid-job SHALL abandon the job with no response; the next job begins with CLEAR, so no generator state carries over.

Verification
REQ-032 req0 n=10 alone, rsp_ready=1 -> req0_ready pulses once; gen_en high for 10 consecutive cycles; rsp_valid at accept+13; rsp_data=89, rsp_id=0, ovf=0.
REQ-033 req0 and req1 both valid from reset, n=5 and n=7 -> req0 served first (8), then req1 (21); a repeated tie then grants req0 over req1 alternately.
REQ-034 n=0 -> rsp_valid 3 cycles after accept, rsp_data=0, gen_en never high.
REQ-035 n=14 and n=15 -> rsp_data=98 and 475 respectively, rsp_ovf=1; n=13 -> 377, ovf=0.
REQ-036 rsp_ready held low 20 cycles in DONE -> outputs stable, req_ready stays 0, busy=1; release -> IDLE next edge.
REQ-037 rst asserted during RUN of an n=12 job -> all outputs at reset values at once; a new n=3 job returns 3.
